// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store stage: opcode encodings and FSM states.
// No logic; imported by load_store_unit and its bench.
// Opcodes other than kLOD/kSTR are ignored by the load/store unit.
package load_store_unit_pkg;

    // Instruction opcodes (4-bit Operation field)
    localparam logic [3:0] kNOP = 4'h0;
    localparam logic [3:0] kADD = 4'h1;
    localparam logic [3:0] kSUB = 4'h2;
    localparam logic [3:0] kCPP = 4'h7;
    localparam logic [3:0] kLOD = 4'h8;
    localparam logic [3:0] kSTR = 4'h9;

    // Load/store unit FSM states
    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_RD,
        LSU_WR
    } lsu_state_t;

endpackage

// File: rtl/lsu_dmem.sv
// Byte-wide data memory, 2**W entries, single synchronous read/write port.
// Latency: read data registered, available the cycle after the address.
// Backpressure: none; contents are not reset.
module lsu_dmem #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_we,
    input  logic [W-1:0] i_addr,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata
);

    logic [W-1:0] r_mem [0:(2**W)-1];
    logic [W-1:0] r_rdata;

    // Write on we; always register the addressed word (read-old on a write)
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: LOD/STR against internal memory, load result written back with a 1-cycle strobe.
// Latency: MEM_LAT busy cycles, WbEn in cycle MEM_LAT+1 (1 cycle on a forwarded load hit).
// Backpressure: Busy holds fetch; Start is ignored while busy. Optional macro: LSU_STORE_FWD_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int W       = 8,
    parameter int A       = 4,
    parameter int MEM_LAT = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [3:0]   Operation,
    input  logic [W-1:0] Addr,
    input  logic [W-1:0] StoreData,
    input  logic [A-1:0] Rtaddr,
    output logic         Busy,
    output logic [W-1:0] DataOut,
    output logic         WbEn,
    output logic [A-1:0] WbAddr
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    lsu_state_t   r_state, w_state_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic [W-1:0] r_addr, w_addr_nxt;
    logic [W-1:0] r_data, w_data_nxt;
    logic [A-1:0] r_rt, w_rt_nxt;
    logic [W-1:0] r_dout, w_dout_nxt;
    logic [A-1:0] r_wbaddr, w_wbaddr_nxt;
    logic         r_wben, w_wben_nxt;
    logic         w_we;
    logic [W-1:0] w_mem_addr;
    logic [W-1:0] w_rdata;
    logic         w_fwd_hit;
    logic [W-1:0] w_fwd_data;

    // In IDLE the memory reads the incoming address so a MEM_LAT=1 load has
    // its data by the end of its single busy cycle; otherwise the latched one.
    assign w_mem_addr = (r_state == LSU_IDLE) ? Addr : r_addr;

    lsu_dmem #(.W(W)) u_dmem (
        .i_clk   (Clk),
        .i_we    (w_we),
        .i_addr  (w_mem_addr),
        .i_wdata (r_data),
        .o_rdata (w_rdata)
    );

`ifdef LSU_STORE_FWD_EN
    logic         r_fwd_vld;
    logic [W-1:0] r_fwd_addr;
    logic [W-1:0] r_fwd_data;

    // Last-store buffer, refreshed on every store commit
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fwd_vld  <= 1'b0;
            r_fwd_addr <= '0;
            r_fwd_data <= '0;
        end else if (w_we) begin
            r_fwd_vld  <= 1'b1;
            r_fwd_addr <= r_addr;
            r_fwd_data <= r_data;
        end
    end

    assign w_fwd_hit  = r_fwd_vld && (Addr == r_fwd_addr);
    assign w_fwd_data = r_fwd_data;
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = '0;
`endif

    // Next-state, latency counter and write-back decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_rt_nxt     = r_rt;
        w_dout_nxt   = r_dout;
        w_wbaddr_nxt = r_wbaddr;
        w_wben_nxt   = 1'b0;
        w_we         = 1'b0;
        unique case (r_state)
            LSU_IDLE: begin
                if (Start && (Operation == kLOD)) begin
                    if (w_fwd_hit) begin
                        // Forwarded load completes without leaving IDLE
                        w_dout_nxt   = w_fwd_data;
                        w_wbaddr_nxt = Rtaddr;
                        w_wben_nxt   = 1'b1;
                    end else begin
                        w_addr_nxt  = Addr;
                        w_rt_nxt    = Rtaddr;
                        w_cnt_nxt   = LAT_M1;
                        w_state_nxt = LSU_RD;
                    end
                end else if (Start && (Operation == kSTR)) begin
                    w_addr_nxt  = Addr;
                    w_data_nxt  = StoreData;
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = LSU_WR;
                end
            end
            LSU_RD: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_dout_nxt   = w_rdata;
                    w_wbaddr_nxt = r_rt;
                    w_wben_nxt   = 1'b1;
                    w_state_nxt  = LSU_IDLE;
                end
            end
            LSU_WR: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_we        = 1'b1;
                    w_state_nxt = LSU_IDLE;
                end
            end
            default: begin
                w_state_nxt = LSU_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= LSU_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_data   <= '0;
            r_rt     <= '0;
            r_dout   <= '0;
            r_wbaddr <= '0;
            r_wben   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_rt     <= w_rt_nxt;
            r_dout   <= w_dout_nxt;
            r_wbaddr <= w_wbaddr_nxt;
            r_wben   <= w_wben_nxt;
        end
    end

    assign Busy    = (r_state != LSU_IDLE);
    assign DataOut = r_dout;
    assign WbEn    = r_wben;
    assign WbAddr  = r_wbaddr;

endmodule
